// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd: in-order circular store queue between the load/store unit and the data-memory port.
// Latency: an accepted push shows at pull_*/count_o the next cycle; the forwarding lookup is combinational.
// Backpressure: push is dropped while full_o=1 and pull is ignored while empty_o=1; there is no internal stall.
//
// Optional feature macro: STORE_BUFFER_FORWARDING_EN. It adds the lookup_*/forward_* ports and the
// store-to-load forwarding comparators. The default build has neither the ports nor the comparators.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   push_*                enqueue request, address, data and width (0=byte, 1=half, 2/3=word)
//   pull_request_i        dequeue request
//   pull_*_o              show-ahead view of the head entry
//   full_o/empty_o        status flags, driven only by registered state
//   count_o               current occupancy
//   lookup_*/forward_*    load lookup against in-flight stores (forwarding build only)
module store_buffer_fwd #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_request_i,
   input  logic [ADDR_W-1:0]      push_address_i,
   input  logic [DATA_W-1:0]      push_data_i,
   input  logic [1:0]             push_width_i,
   output logic                   full_o,
   input  logic                   pull_request_i,
   output logic [ADDR_W-1:0]      pull_address_o,
   output logic [DATA_W-1:0]      pull_data_o,
   output logic [1:0]             pull_width_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
`ifdef STORE_BUFFER_FORWARDING_EN
   ,
   input  logic                   lookup_valid_i,
   input  logic [ADDR_W-1:0]      lookup_address_i,
   output logic                   forward_hit_o,
   output logic [DATA_W-1:0]      forward_data_o,
   output logic                   forward_conflict_o
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_addr  [DEPTH];
   logic [DATA_W-1:0] r_data  [DEPTH];
   logic [1:0]        r_width [DEPTH];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;

   logic w_push_acc;
   logic w_pull_acc;

   assign full_o  = (r_count == CNT_W'(DEPTH));
   assign empty_o = (r_count == '0);
   assign count_o = r_count;

   // Acceptance uses only the registered flags, so a pull cannot make room
   // for a push in the same cycle, and a push cannot feed a pull while empty.
   assign w_push_acc = push_request_i & ~full_o;
   assign w_pull_acc = pull_request_i & ~empty_o;

   assign pull_address_o = r_addr[r_head];
   assign pull_data_o    = r_data[r_head];
   assign pull_width_o   = r_width[r_head];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_acc) r_tail <= r_tail + 1'b1;
         if (w_pull_acc) r_head <= r_head + 1'b1;
         r_count <= r_count + CNT_W'(w_push_acc) - CNT_W'(w_pull_acc);
      end
   end

   // Entry storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_push_acc) begin
         r_addr[r_tail]  <= push_address_i;
         r_data[r_tail]  <= push_data_i;
         r_width[r_tail] <= push_width_i;
      end
   end

`ifdef STORE_BUFFER_FORWARDING_EN
   logic             w_found;
   logic [PTR_W-1:0] w_sel;
   logic             w_exact_word;

   // Walk from the youngest entry (tail-1) towards the oldest; the first
   // word-aligned address match wins. Ages at or beyond count are not live.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PTR_W-1:0] idx;
         idx = r_tail - PTR_W'(i + 1);
         if (!w_found && (CNT_W'(i) < r_count) &&
             (r_addr[idx][ADDR_W-1:2] == lookup_address_i[ADDR_W-1:2])) begin
            w_found = 1'b1;
            w_sel   = idx;
         end
      end
   end

   // Width code 3 is reserved and behaves as a word, so bit 1 marks a word store.
   assign w_exact_word       = r_width[w_sel][1] & (r_addr[w_sel] == lookup_address_i);
   assign forward_hit_o      = lookup_valid_i & w_found & w_exact_word;
   assign forward_conflict_o = lookup_valid_i & w_found & ~w_exact_word;
   assign forward_data_o     = forward_hit_o ? r_data[w_sel] : '0;
`endif

endmodule

// File: tb/tb_store_buffer_fwd.sv
module tb_store_buffer_fwd;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              push_request_i = 1'b0;
   logic [ADDR_W-1:0] push_address_i = '0;
   logic [DATA_W-1:0] push_data_i = '0;
   logic [1:0]        push_width_i = 2'd2;
   logic              full_o;
   logic              pull_request_i = 1'b0;
   logic [ADDR_W-1:0] pull_address_o;
   logic [DATA_W-1:0] pull_data_o;
   logic [1:0]        pull_width_o;
   logic              empty_o;
   logic [3:0]        count_o;
`ifdef STORE_BUFFER_FORWARDING_EN
   logic              lookup_valid_i = 1'b0;
   logic [ADDR_W-1:0] lookup_address_i = '0;
   logic              forward_hit_o;
   logic [DATA_W-1:0] forward_data_o;
   logic              forward_conflict_o;
`endif

   always #5 clk_i = ~clk_i;

   store_buffer_fwd #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .push_request_i(push_request_i),
      .push_address_i(push_address_i),
      .push_data_i(push_data_i),
      .push_width_i(push_width_i),
      .full_o(full_o),
      .pull_request_i(pull_request_i),
      .pull_address_o(pull_address_o),
      .pull_data_o(pull_data_o),
      .pull_width_o(pull_width_o),
      .empty_o(empty_o),
      .count_o(count_o)
`ifdef STORE_BUFFER_FORWARDING_EN
      ,
      .lookup_valid_i(lookup_valid_i),
      .lookup_address_i(lookup_address_i),
      .forward_hit_o(forward_hit_o),
      .forward_data_o(forward_data_o),
      .forward_conflict_o(forward_conflict_o)
`endif
   );

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic [1:0]        w;
   } ent_t;

   ent_t q[$];
   bit   model_ok = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue. Acceptance is decided from the size before the edge.
   always @(posedge clk_i) begin
      bit   pa;
      bit   la;
      ent_t e;
      if (rst_i) begin
         q.delete();
         model_ok = 1'b1;
      end else if (model_ok) begin
         pa = push_request_i && (q.size() < DEPTH);
         la = pull_request_i && (q.size() > 0);
         if (la) void'(q.pop_front());
         if (pa) begin
            e.a = push_address_i;
            e.d = push_data_i;
            e.w = push_width_i;
            q.push_back(e);
         end
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk_i) begin
      if (model_ok) begin
         check("count", count_o, q.size());
         check("empty", empty_o, q.size() == 0);
         check("full", full_o, q.size() == DEPTH);
         if (q.size() > 0) begin
            check("head_addr", pull_address_o, q[0].a);
            check("head_data", pull_data_o, q[0].d);
            check("head_width", pull_width_o, q[0].w);
         end
`ifdef STORE_BUFFER_FORWARDING_EN
         begin
            bit                eh;
            bit                ec;
            logic [DATA_W-1:0] ed;
            eh = 1'b0;
            ec = 1'b0;
            ed = '0;
            if (lookup_valid_i) begin
               for (int k = q.size() - 1; k >= 0; k--) begin
                  if (q[k].a[ADDR_W-1:2] == lookup_address_i[ADDR_W-1:2]) begin
                     if (q[k].w >= 2'd2 && q[k].a == lookup_address_i) begin
                        eh = 1'b1;
                        ed = q[k].d;
                     end else begin
                        ec = 1'b1;
                     end
                     break;
                  end
               end
            end
            check("fwd_hit", forward_hit_o, eh);
            check("fwd_conflict", forward_conflict_o, ec);
            check("fwd_data", forward_data_o, ed);
         end
`endif
      end
   end

   task automatic step(input bit push, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [1:0] w, input bit pull);
      push_request_i = push;
      push_address_i = a;
      push_data_i    = d;
      push_width_i   = w;
      pull_request_i = pull;
      @(posedge clk_i);
      #1;
      push_request_i = 1'b0;
      pull_request_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      step(0, '0, '0, 2'd2, 0);
      step(0, '0, '0, 2'd2, 0);
      rst_i = 1'b0;
      check("rst_empty", empty_o, 1);
      check("rst_full", full_o, 0);
      check("rst_count", count_o, 0);

      // Fill, overflow attempt, drain in order.
      for (int i = 0; i < 8; i++) step(1, 32'h100 + 4 * i, 32'h10 + i, 2'd2, 0);
      check("fill_full", full_o, 1);
      check("fill_count", count_o, 8);
      step(1, 32'h200, 32'hFF, 2'd2, 0);
      check("overflow_count", count_o, 8);
      for (int i = 0; i < 8; i++) begin
         check("drain_order", pull_data_o, 32'h10 + i);
         step(0, '0, '0, 2'd2, 1);
      end
      check("drain_empty", empty_o, 1);

      // Sustained push+pull at count 3 wraps the pointers.
      for (int i = 0; i < 3; i++) step(1, 32'h300 + 4 * i, 32'h20 + i, 2'd2, 0);
      for (int i = 0; i < 20; i++) begin
         check("pp_head", pull_data_o, (i < 3) ? (32'h20 + i) : (32'h30 + i - 3));
         step(1, 32'h400 + 4 * i, 32'h30 + i, 2'd1, 1);
         check("pp_count", count_o, 3);
      end
      for (int i = 0; i < 3; i++) step(0, '0, '0, 2'd2, 1);
      check("pp_empty", empty_o, 1);

      // Push+pull at full: push dropped.
      for (int i = 0; i < 8; i++) step(1, 32'h500 + 4 * i, 32'h40 + i, 2'd2, 0);
      step(1, 32'h600, 32'hAA, 2'd2, 1);
      check("full_pp_count", count_o, 7);
      check("full_pp_full", full_o, 0);
      for (int i = 0; i < 7; i++) begin
         check("full_pp_order", pull_data_o, 32'h41 + i);
         step(0, '0, '0, 2'd2, 1);
      end
      check("full_pp_empty", empty_o, 1);

      // Pull+push while empty: pull ignored.
      step(1, 32'h700, 32'h55, 2'd0, 1);
      check("empty_pp_empty", empty_o, 0);
      check("empty_pp_count", count_o, 1);
      check("empty_pp_data", pull_data_o, 32'h55);
      step(0, '0, '0, 2'd2, 1);

`ifdef STORE_BUFFER_FORWARDING_EN
      step(1, 32'h1000, 32'h11111111, 2'd2, 0);
      step(1, 32'h1000, 32'h22222222, 2'd2, 0);
      lookup_valid_i = 1'b1;
      lookup_address_i = 32'h1000;
      #1;
      check("fwd_young_hit", forward_hit_o, 1);
      check("fwd_young_data", forward_data_o, 32'h22222222);
      step(1, 32'h1001, 32'h33, 2'd0, 0);
      lookup_address_i = 32'h1000;
      #1;
      check("fwd_byte_conflict", forward_conflict_o, 1);
      check("fwd_byte_nohit", forward_hit_o, 0);
      lookup_address_i = 32'h2000;
      #1;
      check("fwd_miss_hit", forward_hit_o, 0);
      check("fwd_miss_conflict", forward_conflict_o, 0);
      check("fwd_miss_data", forward_data_o, 0);
      // A store pushed in the same cycle is not searched.
      push_request_i = 1'b1;
      push_address_i = 32'h3000;
      push_data_i = 32'h77;
      push_width_i = 2'd2;
      lookup_address_i = 32'h3000;
      #1;
      check("fwd_same_cycle", forward_hit_o, 0);
      step(1, 32'h3000, 32'h77, 2'd2, 0);
      lookup_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) step(0, '0, '0, 2'd2, 1);
      lookup_valid_i = 1'b1;
      lookup_address_i = 32'h1000;
`endif

      // Reset beats a simultaneous push and pull at count 5.
      for (int i = 0; i < 5; i++) step(1, 32'h1000, 32'h60 + i, 2'd2, 0);
      check("pre_rst_count", count_o, 5);
      rst_i = 1'b1;
      step(1, 32'h1000, 32'h99, 2'd2, 1);
      rst_i = 1'b0;
      check("rst_mid_count", count_o, 0);
      check("rst_mid_empty", empty_o, 1);
      check("rst_mid_full", full_o, 0);
`ifdef STORE_BUFFER_FORWARDING_EN
      check("rst_mid_hit", forward_hit_o, 0);
      check("rst_mid_conflict", forward_conflict_o, 0);
      check("rst_mid_data", forward_data_o, 0);
`endif

      // Randomized traffic; the compare process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         logic [ADDR_W-1:0] ra;
         ra = 32'h1000 + ($urandom_range(0, 3) << 2) + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
`ifdef STORE_BUFFER_FORWARDING_EN
         lookup_valid_i = ($urandom_range(0, 3) != 0);
         lookup_address_i = 32'h1000 + ($urandom_range(0, 4) << 2) + (($urandom_range(0, 3) == 0) ? 1 : 0);
`endif
         rst_i = ($urandom_range(0, 99) == 0);
         step($urandom_range(0, 9) < 6, ra, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 5);
         rst_i = 1'b0;
      end

      @(negedge clk_i);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
